ddr_write_arbiter: RTL

// - Shares the single AXI write port (AW + W) of ddr3_32 between two frame writers (cam1, cam2).
// - Grants whole bursts round-robin, latches the address phase, then forwards the W beats.
// - Counts the beats and releases the port at the end of each burst.
// - Sits between the per-camera DDR write FIFOs and ddr3_32, in the phy_clk domain.

---
 rtl/ddr_write_arbiter_pkg.sv | 10 +
 rtl/ddr_write_arbiter_if.sv | 32 +++
 rtl/ddr_write_arbiter_rr_arb2.sv | 8 +
 rtl/ddr_write_arbiter.sv | 88 ++++++++
 4 files changed

// File: rtl/ddr_write_arbiter_pkg.sv
// ddr_write_arbiter_pkg: shared FSM state type, strobe constant and grant helper
// for the two-camera DDR write arbiter.
package ddr_write_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} wr_arb_state_t;
  localparam int DEF_DATA_W = 256;
  localparam logic [DEF_DATA_W/8-1:0] STRB_ALL = '1;
  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/ddr_write_arbiter_if.sv
// ddr_write_arbiter_if: requester-side and AXI write-side signals of the arbiter;
// master is the arbiter's view, slave is the view of the FIFOs and ddr3_32 around it.
interface ddr_write_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int LEN_W  = 4,
  parameter int DATA_W = 256
);
  logic [1:0]             req_valid;
  logic [1:0][ADDR_W-1:0] req_addr;
  logic [1:0][LEN_W-1:0]  req_len;
  logic [1:0][DATA_W-1:0] req_wdata;
  logic [1:0]             addr_ack;
  logic [1:0]             wpop;
  logic [1:0]             burst_done;
  logic [ADDR_W-1:0]      axi_awaddr;
  logic [LEN_W-1:0]       axi_awlen;
  logic                   axi_awvalid;
  logic                   axi_awready;
  logic [DATA_W-1:0]      axi_wdata;
  logic [DATA_W/8-1:0]    axi_wstrb;
  logic                   axi_wready;
  logic                   axi_wusero_last;
  logic                   error;
  modport master (
    input  req_valid, req_addr, req_len, req_wdata, axi_awready, axi_wready, axi_wusero_last,
    output addr_ack, wpop, burst_done, axi_awaddr, axi_awlen, axi_awvalid, axi_wdata, axi_wstrb, error
  );
  modport slave (
    output req_valid, req_addr, req_len, req_wdata, axi_awready, axi_wready, axi_wusero_last,
    input  addr_ack, wpop, burst_done, axi_awaddr, axi_awlen, axi_awvalid, axi_wdata, axi_wstrb, error
  );
endinterface

// File: rtl/ddr_write_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick; ptr_i names the requester that wins a tie.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic       grant_o
);
  assign grant_o = (&req_i) ? ptr_i : req_i[1];
endmodule

// File: rtl/ddr_write_arbiter.sv
// ddr_write_arbiter: grants whole AXI write bursts round-robin between two frame writers,
// issues the AW phase, forwards W beats from the granted FIFO and flags protocol errors.
module ddr_write_arbiter
  import ddr_write_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 28,
  parameter int LEN_W    = 4,
  parameter int DATA_W   = 256,
  parameter int MAX_WAIT = 1023
) (
  input logic clk,
  input logic rstn,
  ddr_write_arbiter_if.master bus
);
  localparam int WD_W = $clog2(MAX_WAIT + 1);
  wr_arb_state_t     state_q, state_d;
  logic              grant_q, grant_d, ptr_q, ptr_d, err_q, err_d, pick;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [LEN_W-1:0]  awlen_q, awlen_d, cnt_q, cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              aw_hs, beat, last, wd_hit;
  rr_arb2 u_rr (.req_i(bus.req_valid), .ptr_i(ptr_q), .grant_o(pick));
  assign aw_hs  = state_q == ADDR && bus.axi_awready;
  assign beat   = state_q == DATA && bus.axi_wready;
  assign last   = cnt_q == awlen_q;
  assign wd_hit = wd_q == WD_W'(MAX_WAIT);
  assign bus.addr_ack    = aw_hs ? onehot(grant_q) : 2'b00;
  assign bus.wpop        = beat ? onehot(grant_q) : 2'b00;
  assign bus.burst_done  = beat && last ? onehot(grant_q) : 2'b00;
  assign bus.axi_awvalid = state_q == ADDR;
  assign bus.axi_awaddr  = awaddr_q;
  assign bus.axi_awlen   = awlen_q;
  assign bus.axi_wdata   = state_q == DATA ? bus.req_wdata[grant_q] : '0;
  assign bus.axi_wstrb   = '1;
  assign bus.error       = err_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      ptr_q    <= 1'b0;
      err_q    <= 1'b0;
      awaddr_q <= '0;
      awlen_q  <= '0;
      cnt_q    <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      err_q    <= err_d;
      awaddr_q <= awaddr_d;
      awlen_q  <= awlen_d;
      cnt_q    <= cnt_d;
      wd_q     <= wd_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    awaddr_d = awaddr_q;
    awlen_d  = awlen_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: if (|bus.req_valid) begin
        grant_d  = pick;
        awaddr_d = bus.req_addr[pick];
        awlen_d  = bus.req_len[pick];
        state_d  = ADDR;
      end
      ADDR: if (bus.axi_awready) begin
        cnt_d   = '0;
        state_d = DATA;
      end
      DATA: if (bus.axi_wready) begin
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          ptr_d   = ~grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // watchdog saturates so error stays set while the FSM keeps waiting on AXI
    wd_d  = (state_q == IDLE || aw_hs || beat) ? '0 : (wd_hit ? wd_q : wd_q + 1'b1);
    err_d = err_q | wd_hit | (beat && (bus.axi_wusero_last != last));
  end
endmodule
